// File: rtl/gibbs_sched.sv
// Gibbs sampling scheduler for an RBM accelerator.
// Walks every hidden unit (H-phase), then every visible unit (V-phase), for k
// Gibbs steps. For each unit it requests partial sums from the RBM core,
// waits for the AGS core to return a sampled state, and writes that state
// into the hidden or visible bank of the state buffer.
module gibbs_sched #(
  parameter int NUM_HID = 32,
  parameter int NUM_VIS = 32,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] cfg_k,
  input  logic       abort,
  output logic       ps_req,
  input  logic       ps_ack,
  output logic       ags_en,
  output logic       ags_sel,
  input  logic       state_in,
  input  logic       state_in_en,
  output logic [4:0] unit_idx,
  output logic       st_wr_en,
  output logic       st_wr_bank,
  output logic [4:0] st_wr_addr,
  output logic       st_wr_data,
  output logic [3:0] step,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [4:0]    LAST_H = 5'(NUM_HID - 1);
  localparam logic [4:0]    LAST_V = 5'(NUM_VIS - 1);
  localparam logic [CW-1:0] WLAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE,
    DONE
  } state_t;

  state_t        state, state_n;
  logic          phase, phase_n;
  logic [4:0]    unit_q, unit_n;
  logic [3:0]    step_q, step_n;
  logic [3:0]    k_q, k_n;
  logic [CW-1:0] wcnt, wcnt_n;
  logic          data_q, data_n;
  logic          err_q, err_n;
  logic [4:0]    last;

  assign last = phase ? LAST_V : LAST_H;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Run context: phase, unit index, step count, k, wait counter, sample, err
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase  <= 1'b0;
      unit_q <= '0;
      step_q <= '0;
      k_q    <= 4'd1;
      wcnt   <= '0;
      data_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      phase  <= phase_n;
      unit_q <= unit_n;
      step_q <= step_n;
      k_q    <= k_n;
      wcnt   <= wcnt_n;
      data_q <= data_n;
      err_q  <= err_n;
    end
  end

  // Next-state and run-context update; abort overrides every transition
  always_comb begin
    state_n = state;
    phase_n = phase;
    unit_n  = unit_q;
    step_n  = step_q;
    k_n     = k_q;
    wcnt_n  = wcnt;
    data_n  = data_q;
    err_n   = 1'b0;

    if (abort && (state != IDLE)) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            k_n     = (cfg_k == 4'd0) ? 4'd1 : cfg_k;
            step_n  = '0;
            unit_n  = '0;
            phase_n = 1'b0;
            state_n = REQ;
          end
        end
        REQ: begin
          if (ps_ack) begin
            wcnt_n  = '0;
            state_n = WAIT;
          end
        end
        WAIT: begin
          wcnt_n = wcnt + 1'b1;
          // A sample arriving on the timeout cycle still counts as valid.
          if (state_in_en) begin
            data_n  = state_in;
            state_n = WRITE;
          end else if (wcnt == WLAST) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
        WRITE: begin
          if (unit_q < last) begin
            unit_n  = unit_q + 5'd1;
            state_n = REQ;
          end else if (!phase) begin
            unit_n  = '0;
            phase_n = 1'b1;
            state_n = REQ;
          end else begin
            step_n  = step_q + 4'd1;
            unit_n  = '0;
            phase_n = 1'b0;
            state_n = ((step_q + 4'd1) == k_q) ? DONE : REQ;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from state; abort suppresses the write and done strobes
  always_comb begin
    ps_req     = 1'b0;
    ags_en     = 1'b0;
    st_wr_en   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    ags_sel    = phase;
    unit_idx   = unit_q;
    st_wr_bank = phase;
    st_wr_addr = unit_q;
    st_wr_data = data_q;
    step       = step_q;
    err        = err_q;
    unique case (state)
      REQ: begin
        ps_req = 1'b1;
        ags_en = 1'b1;
      end
      WAIT: begin
        ags_en = 1'b1;
      end
      WRITE: begin
        st_wr_en = !abort;
      end
      DONE: begin
        done = !abort;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_gibbs_sched.sv
// Scoreboard bench for gibbs_sched with 4 hidden / 4 visible units, TIMEOUT 8.
module tb_gibbs_sched;

  localparam int NH = 4;
  localparam int NV = 4;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] cfg_k;
  logic       abort;
  logic       ps_req;
  logic       ps_ack = 1'b0;
  logic       ags_en;
  logic       ags_sel;
  logic       state_in = 1'b0;
  logic       state_in_en = 1'b0;
  logic [4:0] unit_idx;
  logic       st_wr_en;
  logic       st_wr_bank;
  logic [4:0] st_wr_addr;
  logic       st_wr_data;
  logic [3:0] step;
  logic       busy;
  logic       done;
  logic       err;

  gibbs_sched #(.NUM_HID(NH), .NUM_VIS(NV), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_k      (cfg_k),
    .abort      (abort),
    .ps_req     (ps_req),
    .ps_ack     (ps_ack),
    .ags_en     (ags_en),
    .ags_sel    (ags_sel),
    .state_in   (state_in),
    .state_in_en(state_in_en),
    .unit_idx   (unit_idx),
    .st_wr_en   (st_wr_en),
    .st_wr_bank (st_wr_bank),
    .st_wr_addr (st_wr_addr),
    .st_wr_data (st_wr_data),
    .step       (step),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       bank;
    logic [4:0] addr;
    logic       data;
  } wr_t;
  wr_t exp_q[$];

  logic [31:0] pat = 32'hA5C3_96E1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder: RBM core acks at once, AGS core answers resp_delay cycles later
  int   ack_cnt     = 0;
  int   cd          = 0;
  int   resp_delay  = 3;
  int   withhold_at = -1;
  int   wait_entry  = 0;
  bit   idle_stray  = 1'b0;
  bit   req_stray   = 1'b0;
  logic pend_data   = 1'b0;

  initial forever begin
    @(negedge clk);
    state_in_en = 1'b0;
    state_in    = 1'b0;
    if (rst) begin
      cd     = 0;
      ps_ack = 1'b0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          state_in_en = 1'b1;
          state_in    = pend_data;
        end
      end
      ps_ack = ps_req;
      if (ps_req) begin
        if (ack_cnt != withhold_at) begin
          cd        = resp_delay;
          pend_data = pat[ack_cnt % 32];
        end
        wait_entry = cyc + 1;
        if (req_stray) begin
          state_in_en = 1'b1;
          state_in    = ~pat[ack_cnt % 32];
        end
        ack_cnt++;
      end
      if (idle_stray) begin
        state_in_en = 1'b1;
        state_in    = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on every write, counts done/err pulses
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   wr_cnt   = 0;
  int   err_cyc  = 0;
  logic err_busy = 1'b0;
  wr_t  mon_e;

  initial forever begin
    @(negedge clk);
    if (st_wr_en === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got bank %0d addr %0d, required no write (t=%0t)",
                 st_wr_bank, st_wr_addr, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_bank", 32'(st_wr_bank), 32'(mon_e.bank));
        chk("wr_addr", 32'(st_wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(st_wr_data), 32'(mon_e.data));
        chk("ags_sel_at_write", 32'(ags_sel), 32'(mon_e.bank));
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      chk("writes_left_at_done", exp_q.size(), 0);
    end
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc  = cyc;
      err_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_wr(input int bank, input int addr, input int idx);
    wr_t e;
    e.bank = (bank != 0);
    e.addr = 5'(addr);
    e.data = pat[idx % 32];
    exp_q.push_back(e);
  endtask

  // Full run: expected writes go to the scoreboard before start is pulsed
  task automatic run(input logic [3:0] kcfg, input int steps, input int busy_start_at);
    int base, d0, e0, w0, t, idx;
    bit fin;
    base = ack_cnt; d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; idx = base;
    for (int s = 0; s < steps; s++)
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < NH; a++) begin
          push_wr(b, a, idx);
          idx++;
        end
    cfg_k = kcfg;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0; fin = 1'b0;
    while (!fin && t < 3000) begin
      if (t == busy_start_at) begin
        start = 1'b1;
        cfg_k = 4'd5;
      end else begin
        start = 1'b0;
      end
      tick();
      t++;
      if (done_cnt != d0 || err_cnt != e0) fin = 1'b1;
    end
    start = 1'b0;
    chk("run_finished", 32'(fin), 1);
    chk("step_at_done", 32'(step), steps);
    tick();
    chk("busy_after_done", 32'(busy), 0);
    chk("done_pulses", done_cnt - d0, 1);
    chk("err_pulses", err_cnt - e0, 0);
    chk("write_count", wr_cnt - w0, steps * 2 * NH);
    chk("queue_empty", exp_q.size(), 0);
    repeat (3) tick();
    chk("step_hold", 32'(step), steps);
    chk("done_single", done_cnt - d0, 1);
  endtask

  initial begin
    int base, d0, e0, w0, t;
    bit fin;
    rst = 1'b1; start = 1'b0; cfg_k = 4'd0; abort = 1'b0;
    repeat (2) tick();
    chk("reset_outputs",
        32'({ps_req, ags_en, ags_sel, unit_idx, st_wr_en, st_wr_bank, st_wr_addr,
             st_wr_data, step, busy, done, err}), 0);
    rst = 1'b0;
    tick();

    // Basic single step, then cfg_k=0 treated as 1, then three steps
    run(4'd1, 1, -1);
    run(4'd0, 1, -1);
    run(4'd3, 3, -1);

    // Timeout on the 2nd unit
    base = ack_cnt; d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    withhold_at = base + 1;
    push_wr(0, 0, base);
    cfg_k = 4'd1; start = 1'b1; tick(); start = 1'b0;
    t = 0; fin = 1'b0;
    while (!fin && t < 500) begin
      tick(); t++;
      if (err_cnt != e0 || done_cnt != d0) fin = 1'b1;
    end
    chk("timeout_seen", 32'(fin), 1);
    chk("err_latency", err_cyc - wait_entry, TO);
    chk("busy_at_err", 32'(err_busy), 0);
    repeat (2) tick();
    chk("timeout_err_pulses", err_cnt - e0, 1);
    chk("timeout_done_pulses", done_cnt - d0, 0);
    chk("timeout_writes", wr_cnt - w0, 1);
    chk("timeout_queue_empty", exp_q.size(), 0);
    withhold_at = -1;
    repeat (4) tick();

    // Abort during WAIT of unit 2, then a clean run
    base = ack_cnt; d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    push_wr(0, 0, base);
    push_wr(0, 1, base + 1);
    cfg_k = 4'd1; start = 1'b1; tick(); start = 1'b0;
    t = 0;
    while (ack_cnt < base + 3 && t < 200) begin
      tick(); t++;
    end
    chk("abort_reached_unit2", ack_cnt - base, 3);
    tick();
    chk("ags_en_in_wait", 32'(ags_en), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("busy_after_abort", 32'(busy), 0);
    repeat (5) tick();
    chk("abort_done_pulses", done_cnt - d0, 0);
    chk("abort_err_pulses", err_cnt - e0, 0);
    chk("abort_writes", wr_cnt - w0, 2);
    chk("abort_queue_empty", exp_q.size(), 0);
    run(4'd1, 1, -1);

    // Stray state_in_en in IDLE and REQ, start pulsed while busy
    w0 = wr_cnt;
    idle_stray = 1'b1;
    repeat (3) tick();
    idle_stray = 1'b0;
    chk("idle_stray_writes", wr_cnt - w0, 0);
    chk("idle_stray_busy", 32'(busy), 0);
    req_stray = 1'b1;
    run(4'd1, 1, 10);
    req_stray = 1'b0;

    // Sample arriving on the timeout cycle is accepted
    resp_delay = TO;
    run(4'd1, 1, -1);
    resp_delay = 3;

    // Reset mid-run discards the run
    d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
    cfg_k = 4'd2; start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_step", 32'(step), 0);
    chk("midrst_unit", 32'(unit_idx), 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_done", done_cnt - d0, 0);
    chk("midrst_err", err_cnt - e0, 0);
    chk("midrst_writes", wr_cnt - w0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
